tt_extractor: RTL

- Sequential truth-table characterizer for single-output combinational gate netlists with 4 inputs.
- Sweeps every input row into the gate under test (GUT), waits for the output to settle, then samples it several times.
- Packs the samples into the hex truth-table word used to name our synthesized gates; for example, the 0xA2DA netlist must read back 16'hA2DA.
- Sits on the characterization bench beside each synthesized gate. It is the reader of the function that the gate netlist writes.

---
 rtl/tt_extractor.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/tt_extractor.sv
// Truth-table extractor: sweeps all 2**N_IN input rows into a gate under test and packs its output into a hex word.
// Latency: done is high 1 + 2**N_IN*(SETTLE+NSAMP) cycles after the edge that accepts start.
// Backpressure: none; start is honoured only in IDLE, and requests made while busy or finishing are dropped.
//
// Ports:
//   clk, rst      - rising-edge clock, synchronous active-high reset
//   start         - one-cycle sweep request; expected_tt is captured with it
//   dut_in        - drives the gate inputs (row index; dut_in[N_IN-1] is input _0)
//   dut_out       - gate output, sampled NSAMP times per row after SETTLE cycles
//   busy, done    - sweep in progress / one-cycle result strobe
//   tt, match, unstable - result word, compare against expected_tt, sample disagreement
module tt_extractor #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 2,
    parameter int NSAMP  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected_tt,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   tt,
    output logic                 match,
    output logic                 unstable
);

    localparam int TW   = 2**N_IN;
    localparam int CMAX = (SETTLE > NSAMP) ? SETTLE : NSAMP;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] NSAMP_LAST  = CW'(NSAMP - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE_ST,
        SAMPLE,
        FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   row_q;
    logic [CW-1:0]     cnt_q;
    logic [TW-1:0]     shadow_q, shadow_nxt;
    logic [TW-1:0]     exp_q;
    logic              sticky_q, sticky_nxt;
    logic              first_q;
    logic              last_settle, last_samp, last_row;
    logic [N_IN-1:0]   bit_idx;

    // Row r lands in bit TW-1-r; with TW = 2**N_IN that is simply ~r.
    assign bit_idx = ~row_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        busy        = 1'b0;
        done        = 1'b0;
        dut_in      = '0;
        last_settle = (cnt_q == SETTLE_LAST);
        last_samp   = (cnt_q == NSAMP_LAST);
        last_row    = &row_q;
        shadow_nxt  = shadow_q;
        shadow_nxt[bit_idx] = dut_out;
        // Every sample after the first is compared against the row's first sample.
        sticky_nxt  = sticky_q | ((cnt_q != '0) && (dut_out != first_q));
        case (state_q)
            IDLE: begin
                if (start) state_d = SETTLE_ST;
            end
            SETTLE_ST: begin
                busy   = 1'b1;
                dut_in = row_q;
                if (last_settle) state_d = SAMPLE;
            end
            SAMPLE: begin
                busy   = 1'b1;
                dut_in = row_q;
                if (last_samp) state_d = last_row ? FINISH : SETTLE_ST;
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            exp_q    <= '0;
            sticky_q <= 1'b0;
            first_q  <= 1'b0;
            tt       <= '0;
            match    <= 1'b0;
            unstable <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        exp_q    <= expected_tt;
                        shadow_q <= '0;
                        sticky_q <= 1'b0;
                        row_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                SETTLE_ST: begin
                    cnt_q <= last_settle ? '0 : cnt_q + 1'b1;
                end
                SAMPLE: begin
                    shadow_q <= shadow_nxt;
                    sticky_q <= sticky_nxt;
                    if (cnt_q == '0) first_q <= dut_out;
                    if (last_samp) begin
                        cnt_q <= '0;
                        // Results are published on entry to FINISH so they are valid alongside done.
                        if (last_row) begin
                            tt       <= shadow_nxt;
                            match    <= (shadow_nxt == exp_q);
                            unstable <= sticky_nxt;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
